// File: rtl/register_file_ag_pkg.sv
// rtl/register_file_ag_pkg.sv - shared constants and types for the register file / address generator
package register_file_ag_pkg;

  // Register index offsets, added to NUM_GPR to form the special register addresses
  localparam int OFS_ACC    = 0;
  localparam int OFS_DBAR   = 1;
  localparam int OFS_DOFF   = 2;
  localparam int OFS_IBAR   = 3;
  localparam int OFS_IOFF   = 4;
  localparam int OFS_STATUS = 5;

  // STATUS bit positions
  localparam int ZERO_FLAG     = 0;
  localparam int POSITIVE_FLAG = 1;
  localparam int CARRY_FLAG    = 2;
  localparam int OVERFLOW_FLAG = 3;

  typedef enum logic [0:0] {
    PTR_IDLE,
    PTR_CARRY
  } ptr_state_e;

endpackage

// File: rtl/register_file_ag_stepper.sv
// rtl/register_file_ag_stepper.sv - one {BASE, OFF} address pair with offset adder and carry resolution
module addr_pair_stepper #(
  parameter int DATA_W = 8,
  parameter int BASE_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              base_we,
  input  logic [BASE_W-1:0] base_wdata,
  input  logic              off_we,
  input  logic [DATA_W-1:0] off_wdata,
  input  logic              step_en,
  input  logic              step_dec,
  input  logic [DATA_W-1:0] stride,
  input  logic              carry_en,
  input  logic              carry_dec,
  output logic [BASE_W-1:0] base,
  output logic [DATA_W-1:0] off,
  output logic              step_carry,
  output logic              base_wraps
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Offset arithmetic one bit wider so the top bit is the carry (add) or borrow (subtract)
  assign sum        = {1'b0, off} + {1'b0, stride};
  assign diff       = {1'b0, off} - {1'b0, stride};
  assign step_carry = step_dec ? diff[DATA_W] : sum[DATA_W];
  assign base_wraps = carry_dec ? (base == '0) : (&base);

  // Base register: an explicit write beats a pending carry/borrow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base <= '0;
    end else if (base_we) begin
      base <= base_wdata;
    end else if (carry_en) begin
      base <= carry_dec ? base - BASE_W'(1) : base + BASE_W'(1);
    end
  end

  // Offset register: an explicit write beats a pointer step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      off <= '0;
    end else if (off_we) begin
      off <= off_wdata;
    end else if (step_en) begin
      off <= step_dec ? diff[DATA_W-1:0] : sum[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/register_file_ag.sv
// rtl/register_file_ag.sv - parametrised register file with post-increment/decrement address generator
module register_file_ag
  import register_file_ag_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int I_ADDR_WIDTH   = 12,
  parameter int D_ADDR_WIDTH   = 12,
  parameter int NUM_GPR        = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int NUM_RD_PORTS   = 2
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  output logic [DATA_W-1:0]                      acc_out,
  input  logic [DATA_W-1:0]                      acc_in,
  input  logic                                   acc_write_enable,
  input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD_PORTS*DATA_W-1:0]         rd_data,
  input  logic                                   put_enable,
  input  logic [REG_ADDR_WIDTH-1:0]              put_addr,
  input  logic                                   status_write_enable,
  input  logic [3:0]                             flags_in,
  input  logic                                   ptr_valid,
  output logic                                   ptr_ready,
  input  logic                                   ptr_sel,
  input  logic                                   ptr_dec,
  input  logic [DATA_W-1:0]                      ptr_stride,
  output logic                                   ptr_wrap,
  output logic [D_ADDR_WIDTH-1:0]                dmar,
  output logic [I_ADDR_WIDTH-1:0]                imar
);

  localparam int DBASE_W = D_ADDR_WIDTH - DATA_W;
  localparam int IBASE_W = I_ADDR_WIDTH - DATA_W;

  localparam logic [REG_ADDR_WIDTH-1:0] A_ACC    = REG_ADDR_WIDTH'(NUM_GPR + OFS_ACC);
  localparam logic [REG_ADDR_WIDTH-1:0] A_DBAR   = REG_ADDR_WIDTH'(NUM_GPR + OFS_DBAR);
  localparam logic [REG_ADDR_WIDTH-1:0] A_DOFF   = REG_ADDR_WIDTH'(NUM_GPR + OFS_DOFF);
  localparam logic [REG_ADDR_WIDTH-1:0] A_IBAR   = REG_ADDR_WIDTH'(NUM_GPR + OFS_IBAR);
  localparam logic [REG_ADDR_WIDTH-1:0] A_IOFF   = REG_ADDR_WIDTH'(NUM_GPR + OFS_IOFF);
  localparam logic [REG_ADDR_WIDTH-1:0] A_STATUS = REG_ADDR_WIDTH'(NUM_GPR + OFS_STATUS);

  logic [DATA_W-1:0]  gpr [NUM_GPR];
  logic [DATA_W-1:0]  acc;
  logic [DATA_W-1:0]  status;
  logic [DBASE_W-1:0] dbar;
  logic [DATA_W-1:0]  doff;
  logic [IBASE_W-1:0] ibar;
  logic [DATA_W-1:0]  ioff;

  ptr_state_e state;
  logic       lat_sel;
  logic       lat_dec;

  logic d_carry, i_carry, d_wraps, i_wraps;
  logic put_dbar, put_doff, put_ibar, put_ioff;
  logic accept, sel_off_hit, step_ok, step_carry, lat_base_hit, resolve;

  assign put_dbar = put_enable && (put_addr == A_DBAR);
  assign put_doff = put_enable && (put_addr == A_DOFF);
  assign put_ibar = put_enable && (put_addr == A_IBAR);
  assign put_ioff = put_enable && (put_addr == A_IOFF);

  // A PUT to the offset being stepped cancels the step; a PUT to the base being carried cancels the carry
  assign accept       = ptr_valid && ptr_ready;
  assign sel_off_hit  = ptr_sel ? put_ioff : put_doff;
  assign step_ok      = accept && !sel_off_hit;
  assign step_carry   = ptr_sel ? i_carry : d_carry;
  assign lat_base_hit = lat_sel ? put_ibar : put_dbar;
  assign resolve      = (state == PTR_CARRY) && !lat_base_hit;

  // ACC and STATUS; the PUT path reads ACC before this edge updates it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      status <= DATA_W'(8'h03);
    end else begin
      if (acc_write_enable) acc <= acc_in;
      if (status_write_enable) status[OVERFLOW_FLAG:ZERO_FLAG] <= flags_in;
    end
  end

  // General-purpose registers written from ACC by PUT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
    end else if (put_enable) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (put_addr == REG_ADDR_WIDTH'(i)) gpr[i] <= acc;
      end
    end
  end

  // Pointer FSM: a carry/borrow out of OFF costs one extra cycle to ripple into BASE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PTR_IDLE;
      ptr_ready <= 1'b1;
      ptr_wrap  <= 1'b0;
      lat_sel   <= 1'b0;
      lat_dec   <= 1'b0;
    end else begin
      ptr_wrap <= 1'b0;
      case (state)
        PTR_IDLE: begin
          if (step_ok && step_carry) begin
            state     <= PTR_CARRY;
            ptr_ready <= 1'b0;
            lat_sel   <= ptr_sel;
            lat_dec   <= ptr_dec;
          end
        end
        PTR_CARRY: begin
          state     <= PTR_IDLE;
          ptr_ready <= 1'b1;
          ptr_wrap  <= !lat_base_hit && (lat_sel ? i_wraps : d_wraps);
        end
      endcase
    end
  end

  addr_pair_stepper #(.DATA_W(DATA_W), .BASE_W(DBASE_W)) u_data_pair (
    .clk        (clk),
    .reset_n    (reset_n),
    .base_we    (put_dbar),
    .base_wdata (acc[DBASE_W-1:0]),
    .off_we     (put_doff),
    .off_wdata  (acc),
    .step_en    (step_ok && !ptr_sel),
    .step_dec   (ptr_dec),
    .stride     (ptr_stride),
    .carry_en   (resolve && !lat_sel),
    .carry_dec  (lat_dec),
    .base       (dbar),
    .off        (doff),
    .step_carry (d_carry),
    .base_wraps (d_wraps)
  );

  addr_pair_stepper #(.DATA_W(DATA_W), .BASE_W(IBASE_W)) u_instr_pair (
    .clk        (clk),
    .reset_n    (reset_n),
    .base_we    (put_ibar),
    .base_wdata (acc[IBASE_W-1:0]),
    .off_we     (put_ioff),
    .off_wdata  (acc),
    .step_en    (step_ok && ptr_sel),
    .step_dec   (ptr_dec),
    .stride     (ptr_stride),
    .carry_en   (resolve && lat_sel),
    .carry_dec  (lat_dec),
    .base       (ibar),
    .off        (ioff),
    .step_carry (i_carry),
    .base_wraps (i_wraps)
  );

  assign acc_out = acc;
  assign dmar    = {dbar, doff};
  assign imar    = {ibar, ioff};

  for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
    logic [REG_ADDR_WIDTH-1:0] a;
    logic [DATA_W-1:0]         v;
    assign a = rd_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign rd_data[k*DATA_W +: DATA_W] = v;

    // Combinational read of registered state; unmapped addresses read zero
    always_comb begin
      v = '0;
      case (a)
        A_ACC:    v = acc;
        A_DBAR:   v = DATA_W'(dbar);
        A_DOFF:   v = doff;
        A_IBAR:   v = DATA_W'(ibar);
        A_IOFF:   v = ioff;
        A_STATUS: v = status;
        default: begin
          for (int i = 0; i < NUM_GPR; i++) begin
            if (a == REG_ADDR_WIDTH'(i)) v = gpr[i];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_file_ag.sv
// tb/tb_register_file_ag.sv - self-checking bench for register_file_ag
module tb_register_file_ag;

  localparam int N    = 8;
  localparam int ACC  = N;
  localparam int DBAR = N + 1;
  localparam int DOFF = N + 2;
  localparam int IBAR = N + 3;
  localparam int IOFF = N + 4;
  localparam int STAT = N + 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  acc_out;
  logic [7:0]  acc_in = '0;
  logic        acc_write_enable = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        put_enable = 1'b0;
  logic [3:0]  put_addr = '0;
  logic        status_write_enable = 1'b0;
  logic [3:0]  flags_in = '0;
  logic        ptr_valid = 1'b0;
  logic        ptr_ready;
  logic        ptr_sel = 1'b0;
  logic        ptr_dec = 1'b0;
  logic [7:0]  ptr_stride = '0;
  logic        ptr_wrap;
  logic [11:0] dmar;
  logic [11:0] imar;

  always #5 clk = ~clk;

  register_file_ag dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .acc_out             (acc_out),
    .acc_in              (acc_in),
    .acc_write_enable    (acc_write_enable),
    .rd_addr             (rd_addr),
    .rd_data             (rd_data),
    .put_enable          (put_enable),
    .put_addr            (put_addr),
    .status_write_enable (status_write_enable),
    .flags_in            (flags_in),
    .ptr_valid           (ptr_valid),
    .ptr_ready           (ptr_ready),
    .ptr_sel             (ptr_sel),
    .ptr_dec             (ptr_dec),
    .ptr_stride          (ptr_stride),
    .ptr_wrap            (ptr_wrap),
    .dmar                (dmar),
    .imar                (imar)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: architectural register values by address, plus a pending base adjustment
  int r [16];
  int pend, psel, pdec, mwrap;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) r[i] = 0;
    r[STAT] = 3;
    pend  = 0;
    mwrap = 0;
  endtask

  task automatic idle_inputs();
    acc_write_enable    = 1'b0;
    put_enable          = 1'b0;
    status_write_enable = 1'b0;
    ptr_valid           = 1'b0;
  endtask

  // Advance one clock: predict next architectural state from the current inputs, then sample at negedge
  task automatic tick();
    int nr [16];
    int t, bi, oi, nwrap, npend, old_acc;
    if (!reset_n) begin
      model_reset();
      @(posedge clk);
      @(negedge clk);
      return;
    end
    nr = r;
    nwrap = 0;
    npend = 0;
    old_acc = r[ACC];
    if (acc_write_enable) nr[ACC] = int'(acc_in);
    if (status_write_enable) nr[STAT] = (r[STAT] & 'hF0) | int'(flags_in);
    if (pend != 0) begin
      bi = (psel != 0) ? IBAR : DBAR;
      if (!(put_enable && int'(put_addr) == bi)) begin
        t = (pdec != 0) ? r[bi] - 1 : r[bi] + 1;
        nwrap = (t < 0 || t > 15) ? 1 : 0;
        nr[bi] = t & 15;
      end
    end else if (ptr_valid) begin
      oi = ptr_sel ? IOFF : DOFF;
      if (!(put_enable && int'(put_addr) == oi)) begin
        t = ptr_dec ? r[oi] - int'(ptr_stride) : r[oi] + int'(ptr_stride);
        nr[oi] = t & 255;
        if (t < 0 || t > 255) begin
          npend = 1;
          psel = int'(ptr_sel);
          pdec = int'(ptr_dec);
        end
      end
    end
    if (put_enable && put_addr < 4'(STAT + 1) && int'(put_addr) != ACC && int'(put_addr) != STAT)
      nr[put_addr] = (int'(put_addr) == DBAR || int'(put_addr) == IBAR) ? (old_acc & 15) : old_acc;
    @(posedge clk);
    r = nr;
    pend = npend;
    mwrap = nwrap;
    @(negedge clk);
  endtask

  task automatic rd(input int a0, input int a1, output logic [7:0] v0, output logic [7:0] v1);
    rd_addr = {4'(a1), 4'(a0)};
    #1;
    v0 = rd_data[7:0];
    v1 = rd_data[15:8];
  endtask

  task automatic load_reg(input int a, input logic [7:0] val);
    acc_in = val;
    acc_write_enable = 1'b1;
    tick();
    acc_write_enable = 1'b0;
    put_enable = 1'b1;
    put_addr = 4'(a);
    tick();
    put_enable = 1'b0;
  endtask

  task automatic request(input logic sel, input logic dec, input logic [7:0] stride);
    ptr_valid = 1'b1;
    ptr_sel = sel;
    ptr_dec = dec;
    ptr_stride = stride;
    tick();
    ptr_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v0, v1, exp;
    reset_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int a = 0; a < 16; a++) begin
      rd(a, a, v0, v1);
      exp = (a == STAT) ? 8'h03 : 8'h00;
      checks++; if (v0 !== exp) begin errors++; $display("FAIL reset_rd0[%0d] got %h want %h", a, v0, exp); end
      checks++; if (v1 !== exp) begin errors++; $display("FAIL reset_rd1[%0d] got %h want %h", a, v1, exp); end
    end
    checks++; if (dmar !== 12'h000) begin errors++; $display("FAIL reset_dmar got %h want 000", dmar); end
    checks++; if (imar !== 12'h000) begin errors++; $display("FAIL reset_imar got %h want 000", imar); end
    checks++; if (ptr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ptr_ready); end
    checks++; if (ptr_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", ptr_wrap); end
    checks++; if (acc_out !== 8'h00) begin errors++; $display("FAIL reset_acc got %h want 00", acc_out); end
  endtask

  task automatic test_acc_put();
    logic [7:0] v0, v1;
    load_reg(3, 8'h5A);
    rd(3, ACC, v0, v1);
    checks++; if (v0 !== 8'h5A) begin errors++; $display("FAIL put_r3 got %h want 5a", v0); end
    checks++; if (v1 !== 8'h5A) begin errors++; $display("FAIL acc_rd got %h want 5a", v1); end
    acc_in = 8'h11;
    acc_write_enable = 1'b1;
    put_enable = 1'b1;
    put_addr = 4'd4;
    tick();
    idle_inputs();
    rd(4, 3, v0, v1);
    checks++; if (v0 !== 8'h5A) begin errors++; $display("FAIL put_old_acc got %h want 5a", v0); end
    checks++; if (acc_out !== 8'h11) begin errors++; $display("FAIL acc_new got %h want 11", acc_out); end
  endtask

  task automatic test_ptr_simple();
    load_reg(DOFF, 8'h10);
    request(1'b0, 1'b0, 8'd4);
    checks++; if (dmar !== 12'h014) begin errors++; $display("FAIL simple_dmar got %h want 014", dmar); end
    checks++; if (ptr_ready !== 1'b1) begin errors++; $display("FAIL simple_ready got %b want 1", ptr_ready); end
  endtask

  task automatic test_ptr_carry();
    logic [7:0] v0, v1;
    load_reg(DBAR, 8'h02);
    load_reg(DOFF, 8'hFE);
    request(1'b0, 1'b0, 8'd4);
    rd(DOFF, DBAR, v0, v1);
    checks++; if (v0 !== 8'h02) begin errors++; $display("FAIL carry_doff got %h want 02", v0); end
    checks++; if (ptr_ready !== 1'b0) begin errors++; $display("FAIL carry_ready0 got %b want 0", ptr_ready); end
    checks++; if (dmar !== 12'h202) begin errors++; $display("FAIL carry_mid_dmar got %h want 202", dmar); end
    tick();
    checks++; if (dmar !== 12'h302) begin errors++; $display("FAIL carry_dmar got %h want 302", dmar); end
    checks++; if (ptr_ready !== 1'b1) begin errors++; $display("FAIL carry_ready1 got %b want 1", ptr_ready); end
    checks++; if (ptr_wrap !== 1'b0) begin errors++; $display("FAIL carry_wrap got %b want 0", ptr_wrap); end
    load_reg(IBAR, 8'h01);
    load_reg(IOFF, 8'h00);
    request(1'b1, 1'b1, 8'd1);
    tick();
    checks++; if (imar !== 12'h0FF) begin errors++; $display("FAIL borrow_imar got %h want 0ff", imar); end
  endtask

  task automatic test_ptr_wrap();
    load_reg(DBAR, 8'h0F);
    load_reg(DOFF, 8'hFF);
    request(1'b0, 1'b0, 8'd1);
    checks++; if (dmar !== 12'hF00) begin errors++; $display("FAIL wrap_mid_dmar got %h want f00", dmar); end
    tick();
    checks++; if (dmar !== 12'h000) begin errors++; $display("FAIL wrap_dmar got %h want 000", dmar); end
    checks++; if (ptr_wrap !== 1'b1) begin errors++; $display("FAIL wrap_pulse got %b want 1", ptr_wrap); end
    tick();
    checks++; if (ptr_wrap !== 1'b0) begin errors++; $display("FAIL wrap_single got %b want 0", ptr_wrap); end
    load_reg(DBAR, 8'h0F);
    load_reg(DOFF, 8'hFF);
    acc_in = 8'h07;
    acc_write_enable = 1'b1;
    tick();
    acc_write_enable = 1'b0;
    request(1'b0, 1'b0, 8'd1);
    put_enable = 1'b1;
    put_addr = 4'(DBAR);
    tick();
    put_enable = 1'b0;
    checks++; if (dmar !== 12'h700) begin errors++; $display("FAIL put_wins_dmar got %h want 700", dmar); end
    checks++; if (ptr_wrap !== 1'b0) begin errors++; $display("FAIL put_wins_wrap got %b want 0", ptr_wrap); end
    tick();
    checks++; if (ptr_wrap !== 1'b0) begin errors++; $display("FAIL put_wins_wrap2 got %b want 0", ptr_wrap); end
  endtask

  task automatic test_reset_mid_carry();
    load_reg(DOFF, 8'hFF);
    request(1'b0, 1'b0, 8'd1);
    checks++; if (ptr_ready !== 1'b0) begin errors++; $display("FAIL midrst_pre got %b want 0", ptr_ready); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (dmar !== 12'h000) begin errors++; $display("FAIL midrst_dmar got %h want 000", dmar); end
    checks++; if (imar !== 12'h000) begin errors++; $display("FAIL midrst_imar got %h want 000", imar); end
    checks++; if (ptr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", ptr_ready); end
    checks++; if (acc_out !== 8'h00) begin errors++; $display("FAIL midrst_acc got %h want 00", acc_out); end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++; if (ptr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after got %b want 1", ptr_ready); end
    checks++; if (dmar !== 12'h000) begin errors++; $display("FAIL midrst_no_carry got %h want 000", dmar); end
    checks++; if (ptr_wrap !== 1'b0) begin errors++; $display("FAIL midrst_wrap got %b want 0", ptr_wrap); end
  endtask

  task automatic test_random();
    logic [7:0]  v0, v1;
    logic [11:0] ed, ei;
    int a0, a1;
    for (int c = 0; c < 400; c++) begin
      acc_write_enable    = ($urandom_range(0, 2) == 0);
      acc_in              = 8'($urandom);
      put_enable          = ($urandom_range(0, 3) == 0);
      put_addr            = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(DBAR, IOFF)) : 4'($urandom);
      status_write_enable = ($urandom_range(0, 3) == 0);
      flags_in            = 4'($urandom);
      ptr_valid           = ($urandom_range(0, 1) == 0);
      ptr_sel             = 1'($urandom);
      ptr_dec             = 1'($urandom);
      case ($urandom_range(0, 3))
        0: ptr_stride = 8'h00;
        1: ptr_stride = 8'($urandom_range(1, 4));
        default: ptr_stride = 8'($urandom);
      endcase
      tick();
      idle_inputs();
      a0 = int'($urandom_range(0, 15));
      a1 = int'($urandom_range(0, 15));
      rd(a0, a1, v0, v1);
      ed = 12'(r[DBAR] * 256 + r[DOFF]);
      ei = 12'(r[IBAR] * 256 + r[IOFF]);
      checks++; if (v0 !== 8'(r[a0])) begin errors++; $display("FAIL rand_rd0 c=%0d a=%0d got %h want %h", c, a0, v0, 8'(r[a0])); end
      checks++; if (v1 !== 8'(r[a1])) begin errors++; $display("FAIL rand_rd1 c=%0d a=%0d got %h want %h", c, a1, v1, 8'(r[a1])); end
      checks++; if (dmar !== ed) begin errors++; $display("FAIL rand_dmar c=%0d got %h want %h", c, dmar, ed); end
      checks++; if (imar !== ei) begin errors++; $display("FAIL rand_imar c=%0d got %h want %h", c, imar, ei); end
      checks++; if (ptr_ready !== (pend == 0)) begin errors++; $display("FAIL rand_ready c=%0d got %b want %b", c, ptr_ready, pend == 0); end
      checks++; if (ptr_wrap !== (mwrap != 0)) begin errors++; $display("FAIL rand_wrap c=%0d got %b want %b", c, ptr_wrap, mwrap != 0); end
      checks++; if (acc_out !== 8'(r[ACC])) begin errors++; $display("FAIL rand_acc c=%0d got %h want %h", c, acc_out, 8'(r[ACC])); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_acc_put();
    test_ptr_simple();
    test_ptr_carry();
    test_ptr_wrap();
    test_reset_mid_carry();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file_ag.md
Name: register_file_ag

Overview:
Parametrised successor to the CPU register file: GPR count and read-port count are parameters, and PUT uses its own write address. Adds a pointer-arithmetic unit that post-increments or post-decrements the {DBAR,DOFF} / {IBAR,IOFF} address pairs by a stride. Carry or borrow into the base register resolves in a second cycle under a valid/ready handshake. Sits between the decode/control unit and the ALU/memory address path, and drives dmar/imar directly.

Parameters:
DATA_W, 8, register width
I_ADDR_WIDTH, 12, instruction address width (IBAR holds I_ADDR_WIDTH-DATA_W bits)
D_ADDR_WIDTH, 12, data address width (DBAR holds D_ADDR_WIDTH-DATA_W bits)
NUM_GPR, 8, number of general-purpose registers
REG_ADDR_WIDTH, 4, register address width; must be at least clog2(NUM_GPR+6)
NUM_RD_PORTS, 2, number of independent combinational read ports

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
acc_out  out  DATA_W  current ACC value
acc_in  in  DATA_W  ACC write data
acc_write_enable  in  1  load acc_in into ACC
rd_addr  in  NUM_RD_PORTS*REG_ADDR_WIDTH  packed read addresses; port k uses slice k
rd_data  out  NUM_RD_PORTS*DATA_W  packed read data; port k uses slice k
put_enable  in  1  write ACC to register put_addr
put_addr  in  REG_ADDR_WIDTH  PUT target
status_write_enable  in  1  update status flags
flags_in  in  4  {overflow, carry, positive, zero} from ALU
ptr_valid  in  1  pointer operation request
ptr_ready  out  1  pointer unit can accept a request
ptr_sel  in  1  0 = data pair, 1 = instruction pair
ptr_dec  in  1  0 = add stride, 1 = subtract stride
ptr_stride  in  DATA_W  unsigned stride
ptr_wrap  out  1  one-cycle pulse: base register wrapped
dmar  out  D_ADDR_WIDTH  {DBAR, DOFF}
imar  out  I_ADDR_WIDTH  {IBAR, IOFF}

Behaviour:
- Register map constants, with N = NUM_GPR:
  - GPRs at 0..N-1.
  - ACC at N, DBAR at N+1, DOFF at N+2, IBAR at N+3, IOFF at N+4, STATUS at N+5.
  - Any other address reads 0 and ignores writes.
- Reset (asynchronous):
  - All GPRs, ACC, DBAR, DOFF, IBAR and IOFF = 0.
  - STATUS = 8'h03 (zero=1, positive=1).
  - FSM = IDLE, ptr_ready = 1, ptr_wrap = 0, dmar = 0, imar = 0.
- Reads are combinational from registered state; there is no write bypass. A write becomes visible the cycle after its clock edge. DBAR and IBAR read zero-extended.
- ACC write: if acc_write_enable, ACC <= acc_in.
- PUT: if put_enable, reg[put_addr] <= ACC value before the edge, including when acc_write_enable is active in the same cycle.
  - Writes to DBAR/IBAR truncate to the base width.
  - Writes to ACC or STATUS are ignored.
- STATUS: when status_write_enable, bits [3:0] <= flags_in; bits [7:4] hold.
- Pointer FSM:
  - IDLE: ptr_ready = 1. A request is accepted on ptr_valid && ptr_ready.
    - At that edge the selected OFF <= OFF ± ptr_stride, computed DATA_W+1 wide.
    - No carry/borrow: stay IDLE. Back-to-back requests are allowed every cycle.
    - Carry/borrow: latch ptr_sel and ptr_dec, go to CARRY.
  - CARRY: ptr_ready = 0 for exactly one cycle.
    - At the next edge, BASE <= BASE ± 1, modulo 2^(base width); return to IDLE.
    - If BASE wrapped (all-ones to 0 on increment, 0 to all-ones on decrement), ptr_wrap = 1 for the following cycle only.
  - ptr_stride = 0 updates nothing observable and stays IDLE.
- Conflicts, where PUT wins:
  - PUT to the selected OFF in the accept cycle: PUT value is stored, the pointer op is dropped, FSM stays IDLE.
  - PUT to the latched BASE during CARRY: PUT value is stored, the carry is dropped, no ptr_wrap.
  - PUT to the other pair is unaffected.
- Reset asserted mid-CARRY: immediately return to reset state; no pending carry survives.

Decomposition:
- Package register_file_ag_pkg holds:
  - Register index offset constants (OFS_ACC = 0 … OFS_STATUS = 5, added to NUM_GPR).
  - Status bit positions ZERO_FLAG = 0, POSITIVE_FLAG = 1, CARRY_FLAG = 2, OVERFLOW_FLAG = 3.
  - Enum ptr_state_e {PTR_IDLE, PTR_CARRY}.
- One sub-module, addr_pair_stepper: holds one {BASE, OFF} pair, its offset adder and carry resolution. Instantiate it twice (data pair, instruction pair), with the shared FSM in the top level.

Test Plan:
- Reset, then read every index on both ports → GPRs, ACC and pointers = 0, STATUS = 0x03, index N+6 reads 0, dmar = imar = 0.
- acc_in = 0x5A with acc_write_enable, next cycle put_addr = 3 → R3 = 0x5A. Same-cycle acc_write 0x11 with PUT to R4 → R4 gets old ACC.
- DOFF = 0x10, data-pair increment with stride 4 → dmar = 0x014 next cycle, ptr_ready stays 1.
- DBAR = 0x2, DOFF = 0xFE, increment stride 4 → DOFF = 0x02, ptr_ready = 0 for one cycle, then dmar = 0x302. Separately: IBAR = 1, IOFF = 0, decrement stride 1 → imar = 0x0FF after two edges.
- DBAR = 0xF, DOFF = 0xFF, increment stride 1 → dmar = 0x000 and a single-cycle ptr_wrap. Repeat with PUT to DBAR = 0x7 during CARRY → dmar = 0x700, no ptr_wrap.
- Assert reset_n low during CARRY → all outputs return to reset values asynchronously, ptr_ready = 1 after release.
